screen_coord_gen: RTL and testbench

Pipelined stage between the xvga timing generator and the grid/overlay renderers. It converts raw hcount/vcount into signed, zoom-scaled Cartesian coordinates, with the radar origin at a fixed screen point. It also delays the sync and blank signals so they stay aligned with those coordinates. Zoom changes come from single-cycle user requests and take effect only at a frame boundary, so no frame is torn.

---
 rtl/screen_coord_gen.sv | 197 +++++++++++++++++++
 tb/tb_screen_coord_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_coord_gen.sv
// screen_coord_gen
// Turns raw xvga hcount/vcount into signed, zoom-scaled Cartesian coordinates
// centred on the radar origin. The coordinate path is two stages deep, and
// sync/blank are delayed by the same amount so downstream renderers see
// matched data.
//
// Zoom requests are single-cycle pulses. They are latched as a pending request
// and applied only at the frame boundary (hcount == 0 and vcount == 0), so a
// frame is never drawn with two different scales.
//
// Optional feature macro: COORD_SAT_EN
//   defined   : stage 2 saturates scaled coordinates to [-2048, 2047]
//   undefined : stage 2 keeps the low 12 bits, so coordinates wrap
module screen_coord_gen #(
  parameter int ORIGIN_X = 512,
  parameter int ORIGIN_Y = 767,
  parameter int MAX_ZOOM = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic        zoom_up,
  input  logic        zoom_down,
  output logic [11:0] x_value,
  output logic [11:0] y_value,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic [1:0]  zoom_level
);

  // Pending zoom request encoding
  localparam logic [1:0] PEND_NONE = 2'd0;
  localparam logic [1:0] PEND_UP   = 2'd1;
  localparam logic [1:0] PEND_DOWN = 2'd2;

  localparam logic signed [12:0] ORIGIN_X_13 = 13'(ORIGIN_X);
  localparam logic signed [12:0] ORIGIN_Y_13 = 13'(ORIGIN_Y);
  localparam logic [1:0]         MAX_ZOOM_2  = 2'(MAX_ZOOM);

  // Stage 1 registers: origin-relative differences and delayed sync/blank
  logic signed [12:0] r_dx;
  logic signed [12:0] r_dy;
  logic               r_hsync_s1;
  logic               r_vsync_s1;
  logic               r_blank_s1;

  // Stage 2 registers: scaled, width-reduced coordinates and delayed sync/blank
  logic [11:0]        r_x;
  logic [11:0]        r_y;
  logic               r_hsync_s2;
  logic               r_vsync_s2;
  logic               r_blank_s2;

  // Zoom control state
  logic [1:0]         r_zoom_level;
  logic [1:0]         r_pending;

  // Combinational helpers
  logic               w_frame_start;
  logic               w_req_up;
  logic               w_req_down;
  logic signed [12:0] w_dx;
  logic signed [12:0] w_dy;
  logic signed [15:0] w_dx_wide;
  logic signed [15:0] w_dy_wide;
  logic signed [15:0] w_dx_scaled;
  logic signed [15:0] w_dy_scaled;
  logic [11:0]        w_x_reduced;
  logic [11:0]        w_y_reduced;
  logic [1:0]         w_zoom_next;
  logic [1:0]         w_pending_next;

  // Reduces a 16-bit scaled coordinate to the 12-bit output range. With
  // saturation enabled, off-screen values pin to the edge instead of aliasing
  // back onto grid radii or lines.
  function automatic logic [11:0] reduce12(input logic signed [15:0] v);
`ifdef COORD_SAT_EN
    if (v > 16'sd2047) begin
      return 12'h7FF;
    end else if (v < -16'sd2048) begin
      return 12'h800;
    end else begin
      return 12'(v);
    end
`else
    return 12'(v);
`endif
  endfunction

  assign w_frame_start = (hcount == 11'd0) && (vcount == 10'd0);

  // Simultaneous up and down cancel each other and are treated as no request
  assign w_req_up   = zoom_up & ~zoom_down;
  assign w_req_down = zoom_down & ~zoom_up;

  // Inputs are zero-extended so that full-range hcount/vcount never look negative
  assign w_dx = $signed({2'b00, hcount}) - ORIGIN_X_13;
  assign w_dy = ORIGIN_Y_13 - $signed({3'b000, vcount});

  // Stage 2 scales by 2^zoom in a 16-bit field, which holds a 13-bit value
  // shifted by up to 3 without loss
  assign w_dx_wide   = {{3{r_dx[12]}}, r_dx};
  assign w_dy_wide   = {{3{r_dy[12]}}, r_dy};
  assign w_dx_scaled = w_dx_wide <<< r_zoom_level;
  assign w_dy_scaled = w_dy_wide <<< r_zoom_level;
  assign w_x_reduced = reduce12(w_dx_scaled);
  assign w_y_reduced = reduce12(w_dy_scaled);

  // Next zoom level and pending request: apply the pending step at the frame
  // boundary, then let any request seen in this same cycle become the new
  // pending request, so a boundary-cycle request waits for the next frame
  always_comb begin
    w_zoom_next    = r_zoom_level;
    w_pending_next = r_pending;
    if (w_frame_start) begin
      case (r_pending)
        PEND_UP: begin
          if (r_zoom_level < MAX_ZOOM_2) begin
            w_zoom_next = r_zoom_level + 2'd1;
          end
        end
        PEND_DOWN: begin
          if (r_zoom_level != 2'd0) begin
            w_zoom_next = r_zoom_level - 2'd1;
          end
        end
        default: begin
          w_zoom_next = r_zoom_level;
        end
      endcase
      w_pending_next = PEND_NONE;
    end
    if (w_req_up) begin
      w_pending_next = PEND_UP;
    end else if (w_req_down) begin
      w_pending_next = PEND_DOWN;
    end
  end

  // Zoom control registers; reset discards any pending request
  always_ff @(posedge clock) begin
    if (reset) begin
      r_zoom_level <= 2'd0;
      r_pending    <= PEND_NONE;
    end else begin
      r_zoom_level <= w_zoom_next;
      r_pending    <= w_pending_next;
    end
  end

  // Stage 1: capture origin-relative differences alongside sync/blank
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dx       <= 13'sd0;
      r_dy       <= 13'sd0;
      r_hsync_s1 <= 1'b1;
      r_vsync_s1 <= 1'b1;
      r_blank_s1 <= 1'b1;
    end else begin
      r_dx       <= w_dx;
      r_dy       <= w_dy;
      r_hsync_s1 <= hsync;
      r_vsync_s1 <= vsync;
      r_blank_s1 <= blank;
    end
  end

  // Stage 2: scaled coordinates, with sync/blank kept in lockstep
  always_ff @(posedge clock) begin
    if (reset) begin
      r_x        <= 12'd0;
      r_y        <= 12'd0;
      r_hsync_s2 <= 1'b1;
      r_vsync_s2 <= 1'b1;
      r_blank_s2 <= 1'b1;
    end else begin
      r_x        <= w_x_reduced;
      r_y        <= w_y_reduced;
      r_hsync_s2 <= r_hsync_s1;
      r_vsync_s2 <= r_vsync_s1;
      r_blank_s2 <= r_blank_s1;
    end
  end

  assign x_value    = r_x;
  assign y_value    = r_y;
  assign hsync_out  = r_hsync_s2;
  assign vsync_out  = r_vsync_s2;
  assign blank_out  = r_blank_s2;
  assign zoom_level = r_zoom_level;

endmodule

// File: tb/tb_screen_coord_gen.sv
// tb_screen_coord_gen
// Directed bench for screen_coord_gen: reset values, two-cycle alignment of
// coordinates with sync/blank, frame-synchronous zoom, clamping, width
// reduction at maximum zoom (saturating when COORD_SAT_EN is defined), and
// mid-frame reset.
module tb_screen_coord_gen;

  logic               clock = 1'b0;
  logic               reset;
  logic [10:0]        hcount;
  logic [9:0]         vcount;
  logic               hsync;
  logic               vsync;
  logic               blank;
  logic               zoomUp;
  logic               zoomDown;
  logic signed [11:0] xValue;
  logic signed [11:0] yValue;
  logic               hsyncOut;
  logic               vsyncOut;
  logic               blankOut;
  logic [1:0]         zoomLevel;

  int compared   = 0;
  int mismatched = 0;

  screen_coord_gen dut (
    .clock      (clock),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank      (blank),
    .zoom_up    (zoomUp),
    .zoom_down  (zoomDown),
    .x_value    (xValue),
    .y_value    (yValue),
    .hsync_out  (hsyncOut),
    .vsync_out  (vsyncOut),
    .blank_out  (blankOut),
    .zoom_level (zoomLevel)
  );

  // 100 MHz-style free-running clock
  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [10:0] h, input logic [9:0] v,
                               input logic hs, input logic vs, input logic bl);
    hcount = h;
    vcount = v;
    hsync  = hs;
    vsync  = vs;
    blank  = bl;
  endtask

  // Park the scan position somewhere mid-frame so no boundary is seen
  task automatic idle();
    applyStimulus(11'd100, 10'd100, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic pulse(input logic up, input logic dn);
    zoomUp   = up;
    zoomDown = dn;
    step();
    zoomUp   = 1'b0;
    zoomDown = 1'b0;
  endtask

  task automatic frameBoundary();
    hcount = 11'd0;
    vcount = 10'd0;
    step();
    idle();
  endtask

  task automatic test_reset();
    applyStimulus(11'd700, 10'd300, 1'b0, 1'b0, 1'b0);
    zoomUp   = 1'b0;
    zoomDown = 1'b0;
    reset    = 1'b1;
    step();
    step();
    compared++; if (xValue !== 12'sd0) begin mismatched++; $display("[TB] FAIL reset_x: got %0d expected 0", xValue); end
    compared++; if (yValue !== 12'sd0) begin mismatched++; $display("[TB] FAIL reset_y: got %0d expected 0", yValue); end
    compared++; if ({hsyncOut, vsyncOut, blankOut} !== 3'b111) begin mismatched++; $display("[TB] FAIL reset_sync: got %b expected 111", {hsyncOut, vsyncOut, blankOut}); end
    compared++; if (zoomLevel !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_zoom: got %0d expected 0", zoomLevel); end
    reset = 1'b0;
    idle();
  endtask

  task automatic test_origin();
    applyStimulus(11'd512, 10'd767, 1'b1, 1'b1, 1'b0);
    step();
    step();
    compared++; if (xValue !== 12'sd0) begin mismatched++; $display("[TB] FAIL origin_x: got %0d expected 0", xValue); end
    compared++; if (yValue !== 12'sd0) begin mismatched++; $display("[TB] FAIL origin_y: got %0d expected 0", yValue); end
    idle();
  endtask

  // Streams a new vector every cycle; each output cycle must match the
  // vector driven two edges earlier, coordinates and sync/blank alike
  task automatic test_back_to_back();
    logic [10:0]        vh  [6] = '{11'd512, 11'd0,   11'd1023, 11'd600, 11'd400, 11'd512};
    logic [9:0]         vv  [6] = '{10'd767, 10'd100, 10'd767,  10'd500, 10'd767, 10'd1000 - 10'd0};
    logic [2:0]         vs  [6] = '{3'b110,  3'b011,  3'b100,   3'b001,  3'b111,  3'b010};
    logic signed [11:0] ex  [6] = '{12'sd0,  -12'sd512, 12'sd511, 12'sd88, -12'sd112, 12'sd0};
    logic signed [11:0] ey  [6] = '{12'sd0,  12'sd667, 12'sd0,   12'sd267, 12'sd0,   -12'sd233};
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        applyStimulus(vh[i], vv[i], vs[i][2], vs[i][1], vs[i][0]);
      end else begin
        idle();
      end
      step();
      if (i >= 1) begin
        compared++; if (xValue !== ex[i-1]) begin mismatched++; $display("[TB] FAIL stream_x[%0d]: got %0d expected %0d", i-1, xValue, ex[i-1]); end
        compared++; if (yValue !== ey[i-1]) begin mismatched++; $display("[TB] FAIL stream_y[%0d]: got %0d expected %0d", i-1, yValue, ey[i-1]); end
        compared++; if ({hsyncOut, vsyncOut, blankOut} !== vs[i-1]) begin mismatched++; $display("[TB] FAIL stream_sync[%0d]: got %b expected %b", i-1, {hsyncOut, vsyncOut, blankOut}, vs[i-1]); end
      end
    end
    idle();
  endtask

  task automatic test_corner();
    applyStimulus(11'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    step();
    step();
    compared++; if (xValue !== -12'sd512) begin mismatched++; $display("[TB] FAIL corner_x: got %0d expected -512", xValue); end
    compared++; if (yValue !== 12'sd767) begin mismatched++; $display("[TB] FAIL corner_y: got %0d expected 767", yValue); end
    idle();
  endtask

  task automatic test_zoom_defer();
    pulse(1'b1, 1'b0);
    step();
    step();
    compared++; if (zoomLevel !== 2'd0) begin mismatched++; $display("[TB] FAIL defer_hold: got %0d expected 0", zoomLevel); end
    frameBoundary();
    compared++; if (zoomLevel !== 2'd1) begin mismatched++; $display("[TB] FAIL defer_apply: got %0d expected 1", zoomLevel); end
    applyStimulus(11'd612, 10'd767, 1'b1, 1'b1, 1'b0);
    step();
    step();
    compared++; if (xValue !== 12'sd200) begin mismatched++; $display("[TB] FAIL zoom1_x: got %0d expected 200", xValue); end
    compared++; if (yValue !== 12'sd0) begin mismatched++; $display("[TB] FAIL zoom1_y: got %0d expected 0", yValue); end
    idle();
  endtask

  task automatic test_zoom_clamp();
    logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1, 1'b0);
      frameBoundary();
      compared++; if (zoomLevel !== seq[i]) begin mismatched++; $display("[TB] FAIL up_seq[%0d]: got %0d expected %0d", i, zoomLevel, seq[i]); end
    end
    pulse(1'b1, 1'b1);
    frameBoundary();
    compared++; if (zoomLevel !== 2'd3) begin mismatched++; $display("[TB] FAIL both_ignored: got %0d expected 3", zoomLevel); end
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    frameBoundary();
    compared++; if (zoomLevel !== 2'd2) begin mismatched++; $display("[TB] FAIL later_wins: got %0d expected 2", zoomLevel); end
    hcount   = 11'd0;
    vcount   = 10'd0;
    zoomDown = 1'b1;
    step();
    zoomDown = 1'b0;
    idle();
    compared++; if (zoomLevel !== 2'd2) begin mismatched++; $display("[TB] FAIL boundary_req_held: got %0d expected 2", zoomLevel); end
    frameBoundary();
    compared++; if (zoomLevel !== 2'd1) begin mismatched++; $display("[TB] FAIL boundary_req_next: got %0d expected 1", zoomLevel); end
    pulse(1'b0, 1'b1);
    frameBoundary();
    pulse(1'b0, 1'b1);
    frameBoundary();
    compared++; if (zoomLevel !== 2'd0) begin mismatched++; $display("[TB] FAIL down_clamp: got %0d expected 0", zoomLevel); end
  endtask

  task automatic test_wrap();
    logic signed [11:0] expX;
    logic signed [11:0] expY;
`ifdef COORD_SAT_EN
    expX = -12'sd2048;
    expY = 12'sd2047;
`else
    expX = 12'sd0;
    expY = 12'sd2040;
`endif
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0);
      frameBoundary();
    end
    compared++; if (zoomLevel !== 2'd3) begin mismatched++; $display("[TB] FAIL zoom3_reach: got %0d expected 3", zoomLevel); end
    applyStimulus(11'd0, 10'd0, 1'b1, 1'b1, 1'b0);
    step();
    step();
    compared++; if (xValue !== expX) begin mismatched++; $display("[TB] FAIL zoom3_corner_x: got %0d expected %0d", xValue, expX); end
    compared++; if (yValue !== expY) begin mismatched++; $display("[TB] FAIL zoom3_corner_y: got %0d expected %0d", yValue, expY); end
    applyStimulus(11'd600, 10'd700, 1'b1, 1'b1, 1'b0);
    step();
    step();
    compared++; if (xValue !== 12'sd704) begin mismatched++; $display("[TB] FAIL zoom3_x: got %0d expected 704", xValue); end
    compared++; if (yValue !== 12'sd536) begin mismatched++; $display("[TB] FAIL zoom3_y: got %0d expected 536", yValue); end
    idle();
  endtask

  task automatic test_reset_mid();
    pulse(1'b0, 1'b1);
    frameBoundary();
    compared++; if (zoomLevel !== 2'd2) begin mismatched++; $display("[TB] FAIL pre_reset_zoom: got %0d expected 2", zoomLevel); end
    pulse(1'b1, 1'b0);
    applyStimulus(11'd700, 10'd300, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    compared++; if (zoomLevel !== 2'd0) begin mismatched++; $display("[TB] FAIL mid_reset_zoom: got %0d expected 0", zoomLevel); end
    compared++; if (xValue !== 12'sd0 || yValue !== 12'sd0) begin mismatched++; $display("[TB] FAIL mid_reset_xy: got %0d,%0d expected 0,0", xValue, yValue); end
    compared++; if ({hsyncOut, vsyncOut, blankOut} !== 3'b111) begin mismatched++; $display("[TB] FAIL mid_reset_sync: got %b expected 111", {hsyncOut, vsyncOut, blankOut}); end
    idle();
    frameBoundary();
    compared++; if (zoomLevel !== 2'd0) begin mismatched++; $display("[TB] FAIL pending_cleared: got %0d expected 0", zoomLevel); end
  endtask

  initial begin
    reset    = 1'b1;
    zoomUp   = 1'b0;
    zoomDown = 1'b0;
    idle();
    test_reset();
    test_origin();
    test_back_to_back();
    test_corner();
    test_zoom_defer();
    test_zoom_clamp();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
